sfp_norm: RTL
=============

SFP_NORM -- requirements
Module: sfp_norm

Interface
REQ-001 SHALL have parameter COL, default 8, meaning the number of psum elements per vector.
REQ-002 SHALL have parameter BW_PSUM, default 20, meaning the signed width of each psum element.
REQ-003 SHALL have parameter SUM_SHIFT, default 7, meaning the right shift applied to the absolute sum to form the divisor.
REQ-004 SHALL have port clk  input  1  as the single clock.
REQ-005 SHALL have port reset  input  1  as the reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  meaning the input vector is valid.
REQ-007 SHALL have port in_ready  output  1  meaning the block accepts a vector.
REQ-008 SHALL have port in_data  input  COL*BW_PSUM  as the psum vector, with element i at bits [BW_PSUM*(i+1)-1 : BW_PSUM*i].
REQ-009 SHALL have port out_valid  output  1  meaning the normalized vector is valid.
REQ-010 SHALL have port out_ready  input  1  meaning downstream accepts out_data.
REQ-011 SHALL have port out_data  output  COL*BW_PSUM  as the normalized vector, packed like in_data.
REQ-012 SHALL have port out_sum  output  SUM_BW  as the absolute sum of the last vector, where SUM_BW = BW_PSUM + clog2(COL).

Function
REQ-013 SHALL implement FSM states IDLE, ACC, DIV and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; a clock edge with in_valid&&in_ready SHALL capture in_data, clear the sum and element counter, and enter ACC.
REQ-015 ACC SHALL add |element[k]| to the sum, one element per cycle for k=0..COL-1, then enter DIV.
REQ-016 Absolute value SHALL be unsigned BW_PSUM bits, so |-2^(BW_PSUM-1)| = 2^(BW_PSUM-1); the sum SHALL never overflow SUM_BW.
REQ-017 The divisor SHALL be (sum >> SUM_SHIFT) + 1, computed unsigned and never 0.
REQ-018 DIV SHALL write quotient |element[k]| / divisor into output slot k, one per cycle for k=0..COL-1, truncating toward zero, then enter DONE.
REQ-019 out_valid SHALL be 1 only in DONE, rising exactly 2*COL cycles after the accept edge; out_data and out_sum SHALL hold stable while out_valid && !out_ready.
REQ-020 An edge in DONE with out_ready=1 SHALL return the FSM to IDLE, with in_ready=1 on the next cycle; in_valid outside IDLE SHALL be ignored.
REQ-021 The element counter SHALL wrap from COL-1 to 0 at each ACC->DIV and DIV->DONE transition.

Reset
REQ-022 reset low SHALL immediately force IDLE and set in_ready=1 (after release), out_valid=0, out_data=0, out_sum=0, and zero the counter and captured vector, including mid-ACC or mid-DIV.
REQ-023 After reset the first accepted vector SHALL produce a result unaffected by any aborted operation.

Configuration
REQ-024 Macro SFP_NORM_SIGNED_EN defined SHALL give each output element the sign of its input element (two's-complement negation of the quotient when negative).
REQ-025 Without SFP_NORM_SIGNED_EN, every output element SHALL be the unsigned magnitude quotient, zero-extended to BW_PSUM.

Structure
REQ-026 Package sfp_pkg SHALL hold the FSM state typedef and the SUM_BW/divisor-width helper functions.
REQ-027 The combinational abs/divide/sign-restore datapath SHALL be sub-module sfp_div_unit, instantiated once and shared across elements.

Verification (COL=8, BW_PSUM=20, SUM_SHIFT=7)
REQ-028 All elements 128 -> out_sum=1024, divisor 9, every out element 0x0000E, out_valid 16 cycles after accept.
REQ-029 All elements 0 -> divisor 1, out_data=0, out_sum=0.
REQ-030 Element0=-256 and the others 0 -> out_sum=256, divisor 3, element0=85 without the macro and 0xFFFAB with SFP_NORM_SIGNED_EN, others 0.
REQ-031 All elements -524288 -> out_sum=4194304, divisor 32769, every element 15 (unsigned mode).
REQ-032 out_ready held low 5 cycles in DONE -> out_data stable and in_ready=0; out_ready=1 -> IDLE and back-to-back accept next cycle.
REQ-033 reset asserted mid-DIV -> out_valid=0 and out_data=0 immediately; a following vector of all 128 yields all 0x0000E.

Source files
------------

// File: rtl/sfp_norm_pkg.sv
// sfp_pkg: FSM state type and width helpers shared by the sfp_norm psum normaliser.
package sfp_pkg;
  typedef enum logic [1:0] {IDLE, ACC, DIV, DONE} state_t;
  function automatic int sum_bw(input int col, input int bw_psum);
    return bw_psum + $clog2(col);
  endfunction
  // (sum >> shift) + 1 never exceeds 2^(SUM_BW-shift), so one bit above the shifted sum suffices
  function automatic int div_bw(input int col, input int bw_psum, input int shift);
    return (shift >= sum_bw(col, bw_psum)) ? 1 : sum_bw(col, bw_psum) - shift + 1;
  endfunction
endpackage

// File: rtl/sfp_norm_if.sv
// sfp_norm_if: vector-in / vector-out handshake bundle for sfp_norm.
interface sfp_norm_if #(
  parameter int COL = 8,
  parameter int BW_PSUM = 20,
  parameter int SUM_BW = 23
);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [COL*BW_PSUM-1:0] in_data, out_data;
  logic [SUM_BW-1:0] out_sum;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_sum);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_sum);
endinterface

// File: rtl/sfp_div_unit.sv
// sfp_div_unit: magnitude, divide and optional sign restore for one psum element.
// Define SFP_NORM_SIGNED_EN to give each quotient the sign of its input element.
module sfp_div_unit #(
  parameter int BW_PSUM = 20,
  parameter int DIV_BW = 17
) (
  input  logic [BW_PSUM-1:0] elem_i,
  input  logic [DIV_BW-1:0]  divisor_i,
  output logic [BW_PSUM-1:0] abs_o,
  output logic [BW_PSUM-1:0] quot_o
);
  localparam int W = BW_PSUM > DIV_BW ? BW_PSUM : DIV_BW;
  logic [W-1:0] q_w;
  logic [BW_PSUM-1:0] q;
  // unsigned magnitude: the most negative value maps to 2^(BW_PSUM-1)
  assign abs_o = elem_i[BW_PSUM-1] ? -elem_i : elem_i;
  assign q_w = W'(abs_o) / W'(divisor_i);
  assign q = q_w[BW_PSUM-1:0];
`ifdef SFP_NORM_SIGNED_EN
  assign quot_o = elem_i[BW_PSUM-1] ? -q : q;
`else
  assign quot_o = q;
`endif
endmodule

// File: rtl/sfp_norm.sv
// sfp_norm: L1-normalises a COL-element psum vector, one element per cycle for sum then divide.
// Define SFP_NORM_SIGNED_EN to keep input signs on the output elements.
module sfp_norm import sfp_pkg::*; #(
  parameter int COL = 8,
  parameter int BW_PSUM = 20,
  parameter int SUM_SHIFT = 7,
  localparam int SUM_BW = sum_bw(COL, BW_PSUM)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [COL*BW_PSUM-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COL*BW_PSUM-1:0] out_data,
  output logic [SUM_BW-1:0]      out_sum
);
  localparam int DIV_BW = div_bw(COL, BW_PSUM, SUM_SHIFT);
  localparam int CW = COL > 1 ? $clog2(COL) : 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [COL*BW_PSUM-1:0] vec_q, vec_d, res_q, res_d;
  logic [SUM_BW-1:0] sum_q, sum_d;
  logic [BW_PSUM-1:0] elem, abs_v, quot;
  logic [DIV_BW-1:0] divisor;
  logic last;
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_data = res_q;
  assign out_sum = sum_q;
  assign last = cnt_q == CW'(COL - 1);
  assign elem = vec_q[int'(cnt_q)*BW_PSUM +: BW_PSUM];
  assign divisor = DIV_BW'(sum_q >> SUM_SHIFT) + DIV_BW'(1);
  sfp_div_unit #(.BW_PSUM(BW_PSUM), .DIV_BW(DIV_BW)) u_div (
    .elem_i(elem),
    .divisor_i(divisor),
    .abs_o(abs_v),
    .quot_o(quot)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    vec_d = vec_q;
    res_d = res_q;
    sum_d = sum_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = ACC;
        vec_d = in_data;
        sum_d = '0;
        cnt_d = '0;
      end
      ACC: begin
        sum_d = sum_q + SUM_BW'(abs_v);
        cnt_d = last ? '0 : cnt_q + CW'(1);
        state_d = last ? DIV : ACC;
      end
      DIV: begin
        res_d[int'(cnt_q)*BW_PSUM +: BW_PSUM] = quot;
        cnt_d = last ? '0 : cnt_q + CW'(1);
        state_d = last ? DONE : DIV;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      vec_q <= '0;
      res_q <= '0;
      sum_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      vec_q <= vec_d;
      res_q <= res_d;
      sum_q <= sum_d;
    end
endmodule
